// File: rtl/handshake_constant_repeat.sv
// handshake_constant_repeat
//   Elastic constant source. Each control token accepted on ctrl turns into a
//   burst of REPEAT beats of the literal VALUE on outs. Output valid is a
//   register. The only combinational path runs from outs_ready to ctrl_ready,
//   which lets the next token arrive on the last beat so bursts join without a bubble.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   ctrl_valid  control token present
//   ctrl_ready  control token accepted when ctrl_valid && ctrl_ready
//   outs        VALUE while outs_valid, otherwise zero
//   outs_valid  output beat present
//   outs_ready  downstream accepts the beat
//   outs_last   final beat of the current burst
//   busy        burst in progress (same as outs_valid)
//
// REPEAT must be in 1..65535. CNT_W is derived from REPEAT and is not meant
// to be overridden.
module handshake_constant_repeat #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] VALUE      = 32'h3F41_4727,
  parameter int          REPEAT     = 1,
  parameter int          CNT_W      = $clog2(REPEAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  outs_last,
  output logic                  busy
);

  // Zero-extends or truncates VALUE to the output width.
  localparam logic [DATA_WIDTH-1:0] C_VAL  = DATA_WIDTH'(VALUE);
  localparam logic [CNT_W-1:0]      C_LAST = CNT_W'(REPEAT - 1);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_last, w_fire_in, w_fire_out, w_emit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_emit      = (r_state == EMIT);
    w_last      = (r_cnt == C_LAST);
    w_fire_out  = w_emit && outs_ready;
    // While the last beat leaves, the FSM can take the next token. That keeps
    // REPEAT=1 streaming one beat per cycle. The ready is held low during reset.
    ctrl_ready  = rst && (!w_emit || (w_last && outs_ready));
    w_fire_in   = ctrl_valid && ctrl_ready;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_fire_in) begin
          w_state_nxt = EMIT;
          w_cnt_nxt   = '0;
        end
      end
      EMIT: begin
        if (w_fire_out) begin
          if (!w_last) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else if (w_fire_in) begin
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign outs_valid = w_emit;
  assign busy       = w_emit;
  assign outs_last  = w_emit && w_last;
  assign outs       = w_emit ? C_VAL : '0;

endmodule

// File: tb/tb_handshake_constant_repeat.sv
module tb_handshake_constant_repeat;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Three instances: REPEAT=1/32b, REPEAT=4/32b, REPEAT=3/16b.
  localparam int NI = 3;
  int          REP  [NI] = '{1, 4, 3};
  logic [31:0] VALX [NI] = '{32'h3F414727, 32'h3F414727, 32'h00004727};

  logic        cv   [NI];
  logic        ordy [NI];
  logic        crdy [NI];
  logic        ov   [NI];
  logic        ol   [NI];
  logic        bsy  [NI];
  logic [31:0] od0, od1;
  logic [15:0] od2;

  handshake_constant_repeat #(.DATA_WIDTH(32), .REPEAT(1)) u0 (
    .clk(clk), .rst(rst), .ctrl_valid(cv[0]), .ctrl_ready(crdy[0]), .outs(od0),
    .outs_valid(ov[0]), .outs_ready(ordy[0]), .outs_last(ol[0]), .busy(bsy[0]));
  handshake_constant_repeat #(.DATA_WIDTH(32), .REPEAT(4)) u1 (
    .clk(clk), .rst(rst), .ctrl_valid(cv[1]), .ctrl_ready(crdy[1]), .outs(od1),
    .outs_valid(ov[1]), .outs_ready(ordy[1]), .outs_last(ol[1]), .busy(bsy[1]));
  handshake_constant_repeat #(.DATA_WIDTH(16), .VALUE(32'h3F414727), .REPEAT(3)) u2 (
    .clk(clk), .rst(rst), .ctrl_valid(cv[2]), .ctrl_ready(crdy[2]), .outs(od2),
    .outs_valid(ov[2]), .outs_ready(ordy[2]), .outs_last(ol[2]), .busy(bsy[2]));

  function automatic logic [31:0] odat(input int k);
    case (k)
      0:       return od0;
      1:       return od1;
      default: return {16'h0, od2};
    endcase
  endfunction

  int n_cmp = 0;
  int n_bad = 0;
  int beats  [NI] = '{0, 0, 0};
  int tokens [NI] = '{0, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: owed = number of beats still to be delivered, counting the
  // one on display. A token is taken when nothing is owed, or when the single
  // remaining beat leaves this cycle. Each token adds REPEAT beats.
  int owed [NI] = '{0, 0, 0};
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) owed[k] = 0;
    end else begin
      for (int k = 0; k < NI; k++) begin
        int fo, fi;
        fo = (owed[k] > 0 && ordy[k]) ? 1 : 0;
        fi = (cv[k] && (owed[k] == 0 || (owed[k] == 1 && ordy[k]))) ? REP[k] : 0;
        owed[k] = owed[k] - fo + fi;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      logic ev, el, er;
      ev = (owed[k] > 0);
      el = (owed[k] == 1);
      er = rst && (owed[k] == 0 || (owed[k] == 1 && ordy[k]));
      chk($sformatf("i%0d.outs_valid", k), {31'b0, ov[k]},   {31'b0, ev});
      chk($sformatf("i%0d.outs_last", k),  {31'b0, ol[k]},   {31'b0, el});
      chk($sformatf("i%0d.busy", k),       {31'b0, bsy[k]},  {31'b0, ev});
      chk($sformatf("i%0d.ctrl_ready", k), {31'b0, crdy[k]}, {31'b0, er});
      chk($sformatf("i%0d.outs", k),       odat(k),          ev ? VALX[k] : 32'h0);
      if (rst && ov[k] && ordy[k]) beats[k]++;
      if (rst && cv[k] && crdy[k]) tokens[k]++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int b0;
    for (int k = 0; k < NI; k++) begin cv[k] = 1'b0; ordy[k] = 1'b1; end

    // Reset state while rst is low.
    #2;
    chk("rst.outs_valid", {31'b0, ov[1]}, 32'h0);
    chk("rst.ctrl_ready", {31'b0, crdy[0]}, 32'h0);
    chk("rst.outs", od1, 32'h0);
    cyc(2);
    rst = 1'b1;
    cyc(2);

    // REPEAT=1 streaming: 10 tokens give 10 contiguous single-beat bursts.
    cv[0] = 1'b1;
    @(negedge clk);
    chk("t1.no_valid_before_accept", {31'b0, ov[0]}, 32'h0);
    @(negedge clk);
    chk("t1.first_valid", {31'b0, ov[0]}, 32'h1);
    chk("t1.first_last", {31'b0, ol[0]}, 32'h1);
    chk("t1.first_data", od0, 32'h3F414727);
    repeat (9) @(posedge clk);
    #1 cv[0] = 1'b0;
    cyc(3);
    chk("t1.beats", beats[0], 32'd10);
    chk("t1.tokens", tokens[0], 32'd10);

    // REPEAT=4, one token.
    cv[1] = 1'b1;
    cyc(1);
    cv[1] = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      chk($sformatf("t2.valid_b%0d", b), {31'b0, ov[1]}, 32'h1);
      chk($sformatf("t2.last_b%0d", b), {31'b0, ol[1]}, (b == 4) ? 32'h1 : 32'h0);
      chk($sformatf("t2.cready_b%0d", b), {31'b0, crdy[1]}, (b == 4) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    chk("t2.valid_after", {31'b0, ov[1]}, 32'h0);
    chk("t2.outs_after", od1, 32'h0);

    // REPEAT=4 with a stalling consumer: 1,0,0,1,1,0,1 gives exactly 4 fires.
    @(posedge clk); #1;
    b0 = beats[1];
    cv[1] = 1'b1;
    cyc(1);
    cv[1] = 1'b0;
    begin
      logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 7; i++) begin
        ordy[1] = pat[i];
        cyc(1);
      end
    end
    ordy[1] = 1'b1;
    @(negedge clk);
    chk("t3.fires", beats[1] - b0, 32'd4);
    chk("t3.idle_after", {31'b0, ov[1]}, 32'h0);

    // REPEAT=3 with ctrl held high: no bubbles, last on every 3rd beat.
    @(posedge clk); #1;
    cv[2] = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk($sformatf("t4.valid_%0d", i), {31'b0, ov[2]}, 32'h1);
      chk($sformatf("t4.last_%0d", i), {31'b0, ol[2]}, (i % 3 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("t4.data_%0d", i), {16'h0, od2}, 32'h4727);
    end
    @(posedge clk); #1;
    cv[2] = 1'b0;
    cyc(5);

    // Reset in the middle of a REPEAT=4 burst, during the third beat.
    cv[1] = 1'b1;
    cyc(1);
    cv[1] = 1'b0;
    cyc(2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5.async_valid", {31'b0, ov[1]}, 32'h0);
    chk("t5.async_cready", {31'b0, crdy[1]}, 32'h0);
    chk("t5.async_outs", od1, 32'h0);
    for (int k = 0; k < NI; k++) begin beats[k] = 0; tokens[k] = 0; end
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t5.no_beats_after", {31'b0, ov[1]}, 32'h0);
    end

    // Random valid/ready on all instances, then drain.
    @(posedge clk); #1;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < NI; k++) begin
        cv[k]   = ($urandom_range(0, 99) < 60);
        ordy[k] = ($urandom_range(0, 99) < 70);
      end
      cyc(1);
    end
    for (int k = 0; k < NI; k++) begin cv[k] = 1'b0; ordy[k] = 1'b1; end
    cyc(10);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("t6.i%0d.beats_eq_rep_x_tokens", k), beats[k], REP[k] * tokens[k]);
      chk($sformatf("t6.i%0d.idle", k), {31'b0, ov[k]}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
